// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte/half/word RISC-V data memory with req/rsp handshake and configurable read latency.
// Optional per-byte even parity protection when DMEM_PARITY_EN is defined.
module data_mem_ctrl #(
   parameter int DEPTH       = 128,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
   state_t          state_q;
   logic            ready_q, rsp_valid_q, rsp_err_q;
   logic [31:0]     rsp_rdata_q;
   logic [3:0]      cnt_q;
   logic [AW+1:0]   addr_q;
   logic [2:0]      f3_q;
   logic [31:0]     mem_q [DEPTH];
   logic            accept, accept_wr, req_err, par_err;
   logic [3:0]      wr_be;
   logic [31:0]     wr_data, rd_word, ld_data;
   logic [15:0]     rd_half;
   logic [7:0]      rd_byte;
   logic [AW+1:0]   ld_addr;
   logic [2:0]      ld_f3;

   function automatic logic [3:0] lanes(input logic [1:0] a, input logic [2:0] f);
      return f[1:0] == 2'b00 ? 4'b0001 << a : f[1:0] == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   endfunction

   assign accept    = req_valid_i & ready_q;
   assign req_err   = (req_addr_i[31:AW+2] != '0)
                    | (req_funct3_i[1:0] == 2'b01 & req_addr_i[0])
                    | (req_funct3_i == 3'b010 & req_addr_i[1:0] != 2'b00)
                    | (req_funct3_i[1:0] == 2'b11)
                    | (req_funct3_i[2] & (req_funct3_i[1] | req_we_i));
   assign accept_wr = accept & req_we_i & ~req_err & ~rst;
   assign wr_be     = lanes(req_addr_i[1:0], req_funct3_i);
   assign wr_data   = req_funct3_i[1:0] == 2'b00 ? {4{req_wdata_i[7:0]}} :
                      req_funct3_i[1:0] == 2'b01 ? {2{req_wdata_i[15:0]}} : req_wdata_i;

   // In IDLE the load path looks at the live request so zero-wait loads respond next cycle.
   assign ld_addr = state_q == S_IDLE ? req_addr_i[AW+1:0] : addr_q;
   assign ld_f3   = state_q == S_IDLE ? req_funct3_i : f3_q;
   assign rd_word = mem_q[ld_addr[AW+1:2]];
   assign rd_half = ld_addr[1] ? rd_word[31:16] : rd_word[15:0];
   assign rd_byte = ld_addr[0] ? rd_half[15:8] : rd_half[7:0];
   assign ld_data = ld_f3[1:0] == 2'b00 ? {{24{~ld_f3[2] & rd_byte[7]}}, rd_byte} :
                    ld_f3[1:0] == 2'b01 ? {{16{~ld_f3[2] & rd_half[15]}}, rd_half} : rd_word;

   always_ff @(posedge clk)
      if (accept_wr)
         for (int b = 0; b < 4; b++)
            if (wr_be[b]) mem_q[req_addr_i[AW+1:2]][8*b+:8] <= wr_data[8*b+:8];

`ifdef DMEM_PARITY_EN
   logic [3:0] par_q [DEPTH];
   logic [3:0] ld_be;
   assign ld_be = lanes(ld_addr[1:0], ld_f3);
   always_ff @(posedge clk)
      if (accept_wr)
         for (int b = 0; b < 4; b++)
            if (wr_be[b]) par_q[req_addr_i[AW+1:2]][b] <= ^wr_data[8*b+:8];
   always_comb begin
      par_err = 1'b0;
      for (int b = 0; b < 4; b++)
         par_err = par_err | (ld_be[b] & (par_q[ld_addr[AW+1:2]][b] ^ (^rd_word[8*b+:8])));
   end
`else
   assign par_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         cnt_q       <= '0;
         addr_q      <= '0;
         f3_q        <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (accept) begin
               addr_q  <= req_addr_i[AW+1:0];
               f3_q    <= req_funct3_i;
               ready_q <= 1'b0;
               if (!req_err && !req_we_i && WAIT_STATES > 0) begin
                  state_q <= S_WAIT;
                  cnt_q   <= CNT_INIT;
               end else begin
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= req_err | (~req_we_i & par_err);
                  rsp_rdata_q <= (req_err | req_we_i | par_err) ? '0 : ld_data;
               end
            end
            S_WAIT: if (cnt_q == 4'd0) begin
               state_q     <= S_RESP;
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= par_err;
               rsp_rdata_q <= par_err ? '0 : ld_data;
            end else begin
               cnt_q <= cnt_q - 4'd1;
            end
            S_RESP: begin
               state_q     <= S_IDLE;
               rsp_valid_q <= 1'b0;
               ready_q     <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready_o = ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: table-driven directed checks of data_mem_ctrl with three read wait states.
module tb_data_mem_ctrl;
   localparam int WS = 3;
   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [2:0]  req_funct3 = '0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   int          errors = 0, checks = 0;

   data_mem_ctrl #(.DEPTH(128), .WAIT_STATES(WS)) dut (
      .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_funct3_i(req_funct3), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err));

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [2:0]  f3;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        err;
      string       name;
   } vec_t;
   vec_t v[25];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Caller is positioned just after a negedge with the DUT idle.
   task automatic xact(input logic we, input logic [31:0] a, input logic [2:0] f, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
      req_valid = 1'b1; req_we = we; req_addr = a; req_funct3 = f; req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      rd = rsp_rdata; er = rsp_err;
      @(negedge clk);
      chk("pulse_one_cycle", {31'd0, rsp_valid}, 32'd0);
      chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic        seen;
      v[0]  = '{1'b1, 32'h10,  3'b010, 32'h8000_12F0, 32'h0,         1'b0, "sw_10"};
      v[1]  = '{1'b0, 32'h10,  3'b010, 32'h0,         32'h8000_12F0, 1'b0, "lw_10"};
      v[2]  = '{1'b1, 32'h11,  3'b000, 32'h5555_55AB, 32'h0,         1'b0, "sb_11"};
      v[3]  = '{1'b0, 32'h11,  3'b000, 32'h0,         32'hFFFF_FFAB, 1'b0, "lb_11"};
      v[4]  = '{1'b0, 32'h11,  3'b100, 32'h0,         32'h0000_00AB, 1'b0, "lbu_11"};
      v[5]  = '{1'b0, 32'h10,  3'b010, 32'h0,         32'h8000_ABF0, 1'b0, "lw_after_sb"};
      v[6]  = '{1'b0, 32'h12,  3'b001, 32'h0,         32'hFFFF_8000, 1'b0, "lh_12"};
      v[7]  = '{1'b0, 32'h12,  3'b101, 32'h0,         32'h0000_8000, 1'b0, "lhu_12"};
      v[8]  = '{1'b1, 32'h12,  3'b001, 32'hDEAD_1234, 32'h0,         1'b0, "sh_12"};
      v[9]  = '{1'b0, 32'h10,  3'b010, 32'h0,         32'h1234_ABF0, 1'b0, "lw_after_sh"};
      v[10] = '{1'b0, 32'h13,  3'b010, 32'h0,         32'h0,         1'b1, "lw_mis_13"};
      v[11] = '{1'b1, 32'h11,  3'b001, 32'hFFFF_FFFF, 32'h0,         1'b1, "sh_mis_11"};
      v[12] = '{1'b0, 32'h10,  3'b011, 32'h0,         32'h0,         1'b1, "f3_011"};
      v[13] = '{1'b1, 32'h10,  3'b100, 32'h0000_00FF, 32'h0,         1'b1, "sb_f3_100"};
      v[14] = '{1'b1, 32'h200, 3'b010, 32'hFFFF_FFFF, 32'h0,         1'b1, "sw_range"};
      v[15] = '{1'b0, 32'h8000_0010, 3'b010, 32'h0,   32'h0,         1'b1, "lw_addr_hi"};
      v[16] = '{1'b1, 32'h10,  3'b110, 32'hFFFF_FFFF, 32'h0,         1'b1, "st_f3_110"};
      v[17] = '{1'b0, 32'h10,  3'b010, 32'h0,         32'h1234_ABF0, 1'b0, "lw_unchanged"};
      v[18] = '{1'b0, 32'h13,  3'b000, 32'h0,         32'h0000_0012, 1'b0, "lb_13"};
      v[19] = '{1'b1, 32'h1FC, 3'b010, 32'h0,         32'h0,         1'b0, "sw_last"};
      v[20] = '{1'b1, 32'h1FF, 3'b000, 32'h0000_0080, 32'h0,         1'b0, "sb_last"};
      v[21] = '{1'b0, 32'h1FC, 3'b010, 32'h0,         32'h8000_0000, 1'b0, "lw_last"};
      v[22] = '{1'b0, 32'h1FF, 3'b000, 32'h0,         32'hFFFF_FF80, 1'b0, "lb_last"};
      v[23] = '{1'b0, 32'h1FE, 3'b101, 32'h0,         32'h0000_8000, 1'b0, "lhu_last"};
      v[24] = '{1'b0, 32'h1FD, 3'b001, 32'h0,         32'h0,         1'b1, "lh_mis_1fd"};

      @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", {31'd0, rsp_err}, 32'd0);
      rst = 1'b0;

      foreach (v[i]) begin
         xact(v[i].we, v[i].addr, v[i].f3, v[i].wd, rd, er, lat);
         chk({v[i].name, "_rdata"}, rd, v[i].rd);
         chk({v[i].name, "_err"}, {31'd0, er}, {31'd0, v[i].err});
         chk({v[i].name, "_lat"}, lat, (v[i].we || v[i].err) ? 32'd1 : 32'(1 + WS));
      end

      // Ready/valid timeline with req_valid held high across two back-to-back loads.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
      @(posedge clk);
      for (int k = 1; k <= 2 * WS + 4; k++) begin
         @(negedge clk);
         if (k == WS + 3) req_valid = 1'b0;
         chk($sformatf("hold_ready_%0d", k), {31'd0, req_ready},
             {31'd0, !(k <= WS + 1 || (k >= WS + 3 && k <= 2 * WS + 3))});
         chk($sformatf("hold_valid_%0d", k), {31'd0, rsp_valid}, {31'd0, k == WS + 1 || k == 2 * WS + 3});
         if (k == 2 * WS + 3) chk("hold_rdata2", rsp_rdata, 32'h1234_ABF0);
      end

      // Asynchronous reset during WAIT drops the pending response.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("midrst_rdata", rsp_rdata, 32'd0);
      chk("midrst_err", {31'd0, rsp_err}, 32'd0);
      chk("midrst_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < WS + 4; k++) begin
         @(negedge clk);
         seen = seen | rsp_valid;
      end
      chk("midrst_no_rsp", {31'd0, seen}, 32'd0);
      xact(1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
      chk("post_rst_lw", rd, 32'h1234_ABF0);

`ifdef DMEM_PARITY_EN
      xact(1'b0, 32'h11, 3'b100, 32'h0, rd, er, lat);
      chk("par_ok_err", {31'd0, er}, 32'd0);
      dut.par_q[4][1] = ~dut.par_q[4][1];
      xact(1'b0, 32'h11, 3'b100, 32'h0, rd, er, lat);
      chk("par_flip_err", {31'd0, er}, 32'd1);
      chk("par_flip_rdata", rd, 32'd0);
      xact(1'b0, 32'h10, 3'b100, 32'h0, rd, er, lat);
      chk("par_other_lane", {rd[30:0], er}, {31'h0000_00F0, 1'b0});
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
